// File: rtl/tawas_rcn_req_arb.sv
// tawas_rcn_req_arb
//   Arbitrates four requesters onto one buffered rcn master request port and
//   routes master responses back to the originating requester. Each requester
//   may have at most OUTSTANDING_MAX requests in flight.
//
// Configuration:
//   TAWAS_RCN_ARB_FIXED_PRI_EN - when defined, priority is fixed (requester 0
//   highest, 3 lowest). When undefined, priority is round-robin.
//
// Ports:
//   clk, rst                  clock / asynchronous active-high reset
//   req_vld[3:0], req_wr[3:0] per-requester valid and write/read flag
//   req_tag[11:0]             3-bit tag per requester
//   req_mask[15:0]            4-bit byte mask per requester
//   req_addr[95:0]            24-bit address per requester
//   req_wdata[127:0]          32-bit write data per requester
//   req_ack[3:0]              one-hot combinational grant
//   m_cs, m_seq, m_wr, m_mask, m_addr, m_wdata  registered master request
//   m_full                    master request buffer full
//   m_rdone, m_wdone, m_rsp_seq                 master response
//   rsp_rdone[3:0], rsp_wdone[3:0], rsp_tag     routed response

module tawas_rcn_req_arb #(
  parameter int OUTSTANDING_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,

  input  logic [3:0]   req_vld,
  input  logic [3:0]   req_wr,
  input  logic [11:0]  req_tag,
  input  logic [15:0]  req_mask,
  input  logic [95:0]  req_addr,
  input  logic [127:0] req_wdata,
  output logic [3:0]   req_ack,

  output logic         m_cs,
  output logic [4:0]   m_seq,
  output logic         m_wr,
  output logic [3:0]   m_mask,
  output logic [23:0]  m_addr,
  output logic [31:0]  m_wdata,
  input  logic         m_full,

  input  logic         m_rdone,
  input  logic         m_wdone,
  input  logic [4:0]   m_rsp_seq,

  output logic [3:0]   rsp_rdone,
  output logic [3:0]   rsp_wdone,
  output logic [2:0]   rsp_tag
);

  localparam logic [2:0] CNT_MAX = 3'(OUTSTANDING_MAX);

  logic [2:0]  cnt [4];
  logic [3:0]  elig;
  logic [3:0]  ack;
  logic        grant_vld;
  logic [1:0]  grant_idx;

  logic        sel_wr;
  logic [2:0]  sel_tag;
  logic [3:0]  sel_mask;
  logic [23:0] sel_addr;
  logic [31:0] sel_wdata;

  logic        rsp_any;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_hit;

  // Eligibility uses the registered count, so a response arriving this cycle
  // cannot free a slot for a grant in the same cycle.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      elig[i] = !rst && !m_full && req_vld[i] && (cnt[i] < CNT_MAX);
    end
  end

`ifdef TAWAS_RCN_ARB_FIXED_PRI_EN
  always_comb begin
    ack       = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!grant_vld && elig[k]) begin
        ack[k]    = 1'b1;
        grant_vld = 1'b1;
        grant_idx = 2'(k);
      end
    end
  end
`else
  logic [1:0] ptr;

  // Search starts at ptr and wraps modulo 4.
  always_comb begin
    logic [1:0] idx;
    ack       = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!grant_vld && elig[idx]) begin
        ack[idx]  = 1'b1;
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_vld) begin
      ptr <= grant_idx + 2'd1;
    end
  end
`endif

  assign req_ack = ack;

  // One-hot AND-OR select of the granted requester's fields.
  always_comb begin
    sel_wr    = 1'b0;
    sel_tag   = '0;
    sel_mask  = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (ack[i]) begin
        sel_wr    = sel_wr    | req_wr[i];
        sel_tag   = sel_tag   | req_tag[i*3 +: 3];
        sel_mask  = sel_mask  | req_mask[i*4 +: 4];
        sel_addr  = sel_addr  | req_addr[i*24 +: 24];
        sel_wdata = sel_wdata | req_wdata[i*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cs    <= 1'b0;
      m_seq   <= '0;
      m_wr    <= 1'b0;
      m_mask  <= '0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else begin
      m_cs <= grant_vld;
      if (grant_vld) begin
        m_seq   <= {grant_idx, sel_tag};
        m_wr    <= sel_wr;
        m_mask  <= sel_mask;
        m_addr  <= sel_addr;
        m_wdata <= sel_wdata;
      end
    end
  end

  assign rsp_any = m_rdone | m_wdone;
  assign rsp_id  = m_rsp_seq[4:3];

  always_comb begin
    rsp_hit           = '0;
    rsp_hit[rsp_id]   = rsp_any;
    rsp_rdone         = '0;
    rsp_rdone[rsp_id] = m_rdone;
    rsp_wdone         = '0;
    rsp_wdone[rsp_id] = m_wdone;
  end

  assign rsp_tag = m_rsp_seq[2:0];

  // Grant and response together leave the count unchanged; a lone response
  // to an idle requester is forwarded but never underflows the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (ack[i] && !rsp_hit[i]) begin
          cnt[i] <= cnt[i] + 3'd1;
        end else if (!ack[i] && rsp_hit[i] && (cnt[i] != '0)) begin
          cnt[i] <= cnt[i] - 3'd1;
        end
      end
    end
  end

endmodule

// File: doc/tawas_rcn_req_arb.md
TAWAS_RCN_REQ_ARB -- requirements
Module: tawas_rcn_req_arb

Interface
REQ-001 SHALL have parameter OUTSTANDING_MAX, default 4, max in-flight requests per requester (1..7).
REQ-002 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_vld  input  4  per-requester request valid (requester i = bit i).
REQ-005 SHALL have port req_wr  input  4  per-requester write (1) / read (0).
REQ-006 SHALL have port req_tag  input  12  3-bit tag per requester, slice [3i+2:3i].
REQ-007 SHALL have port req_mask  input  16  4-bit byte mask per requester, slice [4i+3:4i].
REQ-008 SHALL have port req_addr  input  96  24-bit address per requester, slice [24i+23:24i].
REQ-009 SHALL have port req_wdata  input  128  32-bit write data per requester, slice [32i+31:32i].
REQ-010 SHALL have port req_ack  output  4  one-hot grant; request consumed in cycle ack is high.
REQ-011 SHALL have ports m_cs 1, m_seq 5, m_wr 1, m_mask 4, m_addr 24, m_wdata 32, all outputs, driving the buffered rcn master request side.
REQ-012 SHALL have port m_full  input  1  buffered master full indication.
REQ-013 SHALL have ports m_rdone 1, m_wdone 1, m_rsp_seq 5, all inputs, from master response side.
REQ-014 SHALL have ports rsp_rdone 4, rsp_wdone 4 (one-hot per requester), rsp_tag 3, all outputs.

Function
REQ-015 Requester i SHALL be eligible when req_vld[i]=1, m_full=0, and outstanding count cnt[i] < OUTSTANDING_MAX.
REQ-016 At most one eligible requester SHALL be granted per cycle; req_ack is combinational from eligibility and priority pointer.
REQ-017 Priority SHALL be round-robin: 2-bit pointer ptr; search order ptr, ptr+1, ..., ptr+3 mod 4; after a grant to i, ptr <= i+1 mod 4 (3 wraps to 0); ptr unchanged without grant.
REQ-018 A grant in cycle N SHALL register in cycle N+1: m_cs=1, m_seq={i[1:0], tag_i}, m_wr, m_mask, m_addr, m_wdata from requester i's slices; m_cs=0 when no grant in N (other m_* hold last value).
REQ-019 m_full=1 SHALL block all grants that cycle; an m_cs already registered SHALL still issue (master reserves 5 entries of slack).
REQ-020 cnt[i] (3 bits) SHALL increment on grant to i and decrement on (m_rdone|m_wdone) with m_rsp_seq[4:3]=i; both same cycle: unchanged.
REQ-021 Response to a requester with cnt=0 SHALL be forwarded but SHALL NOT decrement (no underflow); grant at cnt=OUTSTANDING_MAX is impossible by REQ-015.
REQ-022 Response routing SHALL be combinational: rsp_rdone[i]=m_rdone and rsp_wdone[i]=m_wdone when m_rsp_seq[4:3]=i, else 0; rsp_tag=m_rsp_seq[2:0].
REQ-023 Simultaneous response for i and cnt[i]=OUTSTANDING_MAX SHALL NOT make i eligible in the same cycle (eligibility uses registered cnt).

Reset
REQ-024 On rst: ptr=0, all cnt=0, m_cs=0, m_seq/m_wr/m_mask/m_addr/m_wdata=0; req_ack=0 while rst high.
REQ-025 rst mid-operation SHALL drop any registered m_cs and clear counts; in-flight responses after release are routed per REQ-021.

Configuration
REQ-026 Macro TAWAS_RCN_ARB_FIXED_PRI_EN defined: priority fixed, requester 0 highest, 3 lowest; ptr unused.
REQ-027 Macro undefined: round-robin per REQ-017.

Verification
REQ-028 All four req_vld=1 continuously, m_full=0, responses returned immediately -> req_ack order 0,1,2,3,0,...; m_seq[4:3] matches, m_cs one cycle after each ack.
REQ-029 Requester 2 only, tag 5, no responses, OUTSTANDING_MAX=4 -> exactly 4 acks, cnt[2]=4, then ack held 0; one m_rdone with m_rsp_seq=5'b10101 -> rsp_rdone=4'b0100, rsp_tag=5, ack resumes next cycle.
REQ-030 m_full=1 for 3 cycles with all requesting -> req_ack=0 those cycles, ptr unchanged; first grant after release goes to prior ptr.
REQ-031 Grant to 1 and m_wdone with m_rsp_seq[4:3]=1 same cycle -> cnt[1] unchanged, rsp_wdone=4'b0010.
REQ-032 rst asserted 1 cycle after grant -> m_cs=0 immediately, all cnt=0, ptr=0; with TAWAS_RCN_ARB_FIXED_PRI_EN and all requesting -> requester 0 granted every cycle.
